// File: rtl/motor_pkg.sv
// Shared motor definitions: decoder state and error encodings plus the drive-side
// motor_state encoding.
package motor_pkg;

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StFwd     = 3'd1,
      StGap     = 3'd2,
      StRev     = 3'd3,
      StRecover = 3'd4
   } dec_state_e;

   typedef logic [2:0] err_code_t;

   localparam err_code_t ErrNone   = 3'd0;
   localparam err_code_t ErrShoot  = 3'd1;
   localparam err_code_t ErrFwdLen = 3'd2;
   localparam err_code_t ErrGap    = 3'd3;
   localparam err_code_t ErrRevLen = 3'd4;
   localparam err_code_t ErrOrphan = 3'd5;

   typedef enum logic [1:0] {
      MotReset,
      MotRotate,
      MotWait,
      MotRemain
   } motor_state_e;

   function automatic logic [3:0] sat_inc4(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

endpackage

// File: rtl/bit_sync2.sv
// Two-flop synchroniser for one asynchronous line, synchronously reset to 0.
module bit_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/motor_pulse_decoder.sv
// Checks the A/B motor drive pair for one eject cycle (A pulse, gap, B pulse),
// counts completed cards and flags malformed or unsafe waveforms.
module motor_pulse_decoder
   import motor_pkg::*;
#(
   parameter int unsigned FWD_MIN = 1,
   parameter int unsigned FWD_MAX = 3,
   parameter int unsigned GAP_MAX = 2,
   parameter int unsigned REV_MIN = 1,
   parameter int unsigned REV_MAX = 2,
   parameter int unsigned CNT_W   = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic             a_in,
   input  logic             b_in,
   input  logic             clr,
   output logic             busy,
   output logic             card_done,
   output logic [CNT_W-1:0] card_count,
   output logic             err,
   output logic [2:0]       err_code
);

   localparam logic [3:0] FwdMin = 4'(FWD_MIN);
   localparam logic [3:0] FwdMax = 4'(FWD_MAX);
   localparam logic [3:0] GapMax = 4'(GAP_MAX);
   localparam logic [3:0] RevMin = 4'(REV_MIN);
   localparam logic [3:0] RevMax = 4'(REV_MAX);

   logic a_s, b_s;

   bit_sync2 u_a_sync (.clk(clk), .rst(rst), .d(a_in), .q(a_s));
   bit_sync2 u_b_sync (.clk(clk), .rst(rst), .d(b_in), .q(b_s));

   dec_state_e       state_q, state_d;
   logic [3:0]       len_q, len_d;
   logic             done_d, err_d;
   err_code_t        code_d;
   logic             busy_q, card_done_q, err_q;
   logic [CNT_W-1:0] card_count_q;
   err_code_t        err_code_q;

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      code_d  = ErrNone;
      if (tick) begin
         // Shoot-through outranks every per-state rule.
         if (state_q != StRecover && a_s && b_s) begin
            err_d  = 1'b1;
            code_d = ErrShoot;
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (a_s) begin
                     state_d = StFwd;
                     len_d   = 4'd1;
                  end else if (b_s) begin
                     err_d  = 1'b1;
                     code_d = ErrOrphan;
                  end
               end
               StFwd: begin
                  if (a_s) begin
                     if (len_q >= FwdMax) begin
                        err_d  = 1'b1;
                        code_d = ErrFwdLen;
                     end else begin
                        len_d = sat_inc4(len_q);
                     end
                  end else if (len_q < FwdMin) begin
                     err_d  = 1'b1;
                     code_d = ErrFwdLen;
                  end else begin
                     state_d = b_s ? StRev : StGap;
                     len_d   = 4'd1;
                  end
               end
               StGap: begin
                  if (a_s) begin
                     err_d  = 1'b1;
                     code_d = ErrGap;
                  end else if (b_s) begin
                     state_d = StRev;
                     len_d   = 4'd1;
                  end else if (len_q >= GapMax) begin
                     err_d  = 1'b1;
                     code_d = ErrGap;
                  end else begin
                     len_d = sat_inc4(len_q);
                  end
               end
               StRev: begin
                  if (a_s) begin
                     err_d  = 1'b1;
                     code_d = ErrRevLen;
                  end else if (b_s) begin
                     if (len_q >= RevMax) begin
                        err_d  = 1'b1;
                        code_d = ErrRevLen;
                     end else begin
                        len_d = sat_inc4(len_q);
                     end
                  end else if (len_q < RevMin) begin
                     err_d  = 1'b1;
                     code_d = ErrRevLen;
                  end else begin
                     done_d  = 1'b1;
                     state_d = StIdle;
                     len_d   = 4'd0;
                  end
               end
               StRecover: begin
                  if (!a_s && !b_s) begin
                     state_d = StIdle;
                     len_d   = 4'd0;
                  end
               end
               default: begin
                  state_d = StIdle;
                  len_d   = 4'd0;
               end
            endcase
         end
         if (err_d) begin
            state_d = StRecover;
            len_d   = 4'd0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         len_q        <= 4'd0;
         busy_q       <= 1'b0;
         card_done_q  <= 1'b0;
         err_q        <= 1'b0;
         card_count_q <= '0;
         err_code_q   <= ErrNone;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         busy_q      <= (state_d == StFwd) || (state_d == StGap) || (state_d == StRev);
         card_done_q <= done_d;
         err_q       <= err_d;
         // A new error outranks a simultaneous clear.
         if (err_d) begin
            err_code_q <= code_d;
         end else if (clr) begin
            err_code_q <= ErrNone;
         end
         if (clr) begin
            card_count_q <= '0;
         end else if (done_d && card_count_q != '1) begin
            card_count_q <= card_count_q + CNT_W'(1);
         end
      end
   end

   assign busy       = busy_q;
   assign card_done  = card_done_q;
   assign card_count = card_count_q;
   assign err        = err_q;
   assign err_code   = err_code_q;

endmodule

// File: tb/tb_motor_pulse_decoder.sv
// Directed bench for motor_pulse_decoder: nominal cycles, saturation, every error
// code, reset mid-cycle and clear coincidences.
module tb_motor_pulse_decoder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick = 1'b0;
   logic       a_in = 1'b0;
   logic       b_in = 1'b0;
   logic       clr = 1'b0;
   logic       busy, card_done, err;
   logic [5:0] card_count;
   logic [2:0] err_code;
   logic       busy2, card_done2, err2;
   logic [1:0] card_count2;
   logic [2:0] err_code2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   motor_pulse_decoder dut (
      .clk(clk), .rst(rst), .tick(tick), .a_in(a_in), .b_in(b_in), .clr(clr),
      .busy(busy), .card_done(card_done), .card_count(card_count),
      .err(err), .err_code(err_code)
   );

   motor_pulse_decoder #(.CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .tick(tick), .a_in(a_in), .b_in(b_in), .clr(clr),
      .busy(busy2), .card_done(card_done2), .card_count(card_count2),
      .err(err2), .err_code(err_code2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Hold A/B for three clocks so the synchroniser settles, then one tick clock;
   // returns on the negedge where the registered decision is visible.
   task automatic step(input logic a, input logic b, input logic c = 1'b0);
      a_in = a;
      b_in = b;
      tick = 1'b0;
      clr  = 1'b0;
      repeat (3) @(negedge clk);
      tick = 1'b1;
      clr  = c;
      @(negedge clk);
      tick = 1'b0;
      clr  = 1'b0;
   endtask

   logic any_err, early_done;

   task automatic nominal(input logic c = 1'b0);
      any_err    = 1'b0;
      early_done = 1'b0;
      step(1'b1, 1'b0); any_err |= err; early_done |= card_done;
      step(1'b1, 1'b0); any_err |= err; early_done |= card_done;
      step(1'b0, 1'b0); any_err |= err; early_done |= card_done;
      step(1'b0, 1'b1); any_err |= err; early_done |= card_done;
      step(1'b0, 1'b0, c); any_err |= err;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", card_done, 0);
      chk("rst_count", card_count, 0);
      chk("rst_err", err, 0);
      chk("rst_code", err_code, 0);
      rst = 1'b0;
      @(negedge clk);

      // 1. nominal cycle
      step(1'b1, 1'b0);
      chk("fwd_busy", busy, 1);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      chk("rev_no_done", card_done, 0);
      step(1'b0, 1'b0);
      chk("nom_done", card_done, 1);
      chk("nom_count", card_count, 1);
      chk("nom_idle_busy", busy, 0);
      @(negedge clk);
      chk("done_one_clk", card_done, 0);

      // 2. back-to-back cycles and saturation on the narrow counter
      for (int i = 0; i < 4; i++) nominal();
      chk("sat5_count2", card_count2, 3);
      chk("cnt5_count", card_count, 5);
      for (int i = 0; i < 5; i++) nominal();
      chk("ten_count", card_count, 10);
      chk("ten_err_none", any_err, 0);
      chk("sat10_count2", card_count2, 3);

      // 3. A too long
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      chk("fwd3_no_err", err, 0);
      step(1'b1, 1'b0);
      chk("fwdlen_err", err, 1);
      chk("fwdlen_code", err_code, 2);
      chk("fwdlen_no_done", card_done, 0);
      chk("recover_busy", busy, 0);
      step(1'b0, 1'b0);
      chk("err_one_clk", err, 0);
      nominal();
      chk("after_rec_done", card_done, 1);
      chk("after_rec_count", card_count, 11);
      chk("code_sticky", err_code, 2);

      // 4. shoot-through and orphan reverse
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      chk("shoot_err", err, 1);
      chk("shoot_code", err_code, 1);
      step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      chk("orphan_err", err, 1);
      chk("orphan_code", err_code, 5);
      step(1'b0, 1'b0);

      // 5. gap too long, B too long, zero gap
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      chk("gap2_no_err", err, 0);
      step(1'b0, 1'b0);
      chk("gap_err", err, 1);
      chk("gap_code", err_code, 3);
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      chk("rev2_no_err", err, 0);
      step(1'b0, 1'b1);
      chk("revlen_code", err_code, 4);
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b1);
      chk("zgap_busy", busy, 1);
      step(1'b0, 1'b0);
      chk("zgap_done", card_done, 1);
      chk("zgap_count", card_count, 12);

      // 6. reset during REV
      step(1'b1, 1'b0);
      step(1'b0, 1'b1);
      rst  = 1'b1;
      a_in = 1'b0;
      b_in = 1'b0;
      repeat (2) @(negedge clk);
      chk("midrst_busy", busy, 0);
      chk("midrst_count", card_count, 0);
      chk("midrst_code", err_code, 0);
      rst = 1'b0;
      step(1'b0, 1'b0);
      chk("midrst_no_done", card_done, 0);

      // clear coincident with card_done, then with an error
      nominal();
      nominal();
      chk("pre_clr_count", card_count, 2);
      nominal(1'b1);
      chk("clr_done", card_done, 1);
      chk("clr_count", card_count, 0);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b1);
      chk("clr_err_code", err_code, 2);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      chk("clr_code", err_code, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
